wb_regs: RTL

WB_REGS -- requirements
Module: wb_regs

---
 rtl/wb_regs_pkg.sv | 24 ++
 rtl/wb_hilo_ll.sv | 82 ++++++++
 rtl/wb_regs.sv | 115 +++++++++++
 3 files changed

// File: rtl/wb_regs_pkg.sv
// -----------------------------------------------------------------------------
// wb_regs_pkg -- shared defines for the write-back register file slice.
//
// Holds the bus widths, zero constants and the polarity encodings of the
// enable/reset signals. Modules import this package so every comparison
// against an enable or a null address reads the same way everywhere.
// -----------------------------------------------------------------------------
package wb_regs_pkg;

    // Default data and GPR address widths.
    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    // Zero constants at the default widths.
    localparam logic [RegBus-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

    // Signal polarity encodings.
    localparam logic WriteEna  = 1'b1;
    localparam logic WriteDisa = 1'b0;
    localparam logic RstEna    = 1'b1;
    localparam logic ReadEna   = 1'b1;

endpackage : wb_regs_pkg

// File: rtl/wb_hilo_ll.sv
// -----------------------------------------------------------------------------
// wb_hilo_ll -- HI/LO special registers and the load-linked bit.
//
// Optional feature macro: WB_REGS_BYPASS_EN
//   defined   : outputs show this cycle's write request combinationally
//   undefined : outputs come from stored state only
//
// Ports
//   clk, rst                      clock, async active-high reset
//   wb_whilo, wb_hi, wb_lo        HI/LO write request (both written together)
//   wb_LLbit_we, wb_LLbit_value   LLbit write request
//   flush                         exception flush, clears LLbit (wins over we)
//   hi_o, lo_o, LLbit_o           current HI, LO, LLbit
// -----------------------------------------------------------------------------
module wb_hilo_ll
    import wb_regs_pkg::*;
#(
    parameter int DATA_W = RegBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_LLbit_we,
    input  logic              wb_LLbit_value,
    input  logic              flush,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              LLbit_o
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              llbit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEna) begin
            hi_q    <= DATA_W'(ZeroWord);
            lo_q    <= DATA_W'(ZeroWord);
            llbit_q <= 1'b0;
        end else begin
            if (wb_whilo == WriteEna) begin
                hi_q <= wb_hi;
                lo_q <= wb_lo;
            end
            // A flush squashes any reservation, even one being set this cycle.
            if (flush) begin
                llbit_q <= 1'b0;
            end else if (wb_LLbit_we == WriteEna) begin
                llbit_q <= wb_LLbit_value;
            end
        end
    end

`ifdef WB_REGS_BYPASS_EN
    // Forwarding is suppressed during reset so reads there stay at zero.
    always_comb begin
        hi_o    = hi_q;
        lo_o    = lo_q;
        LLbit_o = llbit_q;
        if (rst != RstEna) begin
            if (wb_whilo == WriteEna) begin
                hi_o = wb_hi;
                lo_o = wb_lo;
            end
            if (flush) begin
                LLbit_o = 1'b0;
            end else if (wb_LLbit_we == WriteEna) begin
                LLbit_o = wb_LLbit_value;
            end
        end
    end
`else
    always_comb begin
        hi_o    = hi_q;
        lo_o    = lo_q;
        LLbit_o = llbit_q;
    end
`endif

endmodule : wb_hilo_ll

// File: rtl/wb_regs.sv
// -----------------------------------------------------------------------------
// wb_regs -- general purpose register file with two read ports, plus the
// HI/LO/LLbit block (wb_hilo_ll).
//
// Optional feature macro: WB_REGS_BYPASS_EN
//   defined   : a read of the register being written this cycle returns the
//               write data; HI/LO/LLbit likewise forward
//   undefined : all outputs come from stored state only
//
// Ports
//   clk, rst                         clock, async active-high reset
//   wb_reg, wb_waddr, wb_wdata       GPR write request from MEM/WB
//   wb_whilo, wb_hi, wb_lo           HI/LO write request
//   wb_LLbit_we, wb_LLbit_value      LLbit write request
//   flush                            exception flush (LLbit only)
//   re1, raddr1, rdata1              read port 1
//   re2, raddr2, rdata2              read port 2
//   hi_o, lo_o, LLbit_o              current HI, LO, LLbit
//
// Register 0 is hardwired to zero: writes to it are dropped and reads of it
// return zero regardless of any pending write.
// -----------------------------------------------------------------------------
module wb_regs
    import wb_regs_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_reg,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_LLbit_we,
    input  logic              wb_LLbit_value,
    input  logic              flush,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              LLbit_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(NOPRegAddr);

    logic [DATA_W-1:0] gpr [DEPTH];

    logic gpr_we;
    assign gpr_we = (wb_reg == WriteEna) && (wb_waddr != ZERO_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEna) begin
            for (int i = 0; i < DEPTH; i++) begin
                gpr[i] <= DATA_W'(ZeroWord);
            end
        end else if (gpr_we) begin
            gpr[wb_waddr] <= wb_wdata;
        end
    end

`ifdef WB_REGS_BYPASS_EN
    // Forward only while out of reset, so reads during reset stay zero.
    logic fwd_ok;
    assign fwd_ok = gpr_we && (rst != RstEna);
`endif

    always_comb begin
        rdata1 = DATA_W'(ZeroWord);
        if ((re1 == ReadEna) && (raddr1 != ZERO_ADDR)) begin
            rdata1 = gpr[raddr1];
`ifdef WB_REGS_BYPASS_EN
            if (fwd_ok && (wb_waddr == raddr1)) begin
                rdata1 = wb_wdata;
            end
`endif
        end
    end

    always_comb begin
        rdata2 = DATA_W'(ZeroWord);
        if ((re2 == ReadEna) && (raddr2 != ZERO_ADDR)) begin
            rdata2 = gpr[raddr2];
`ifdef WB_REGS_BYPASS_EN
            if (fwd_ok && (wb_waddr == raddr2)) begin
                rdata2 = wb_wdata;
            end
`endif
        end
    end

    wb_hilo_ll #(
        .DATA_W (DATA_W)
    ) u_hilo_ll (
        .clk            (clk),
        .rst            (rst),
        .wb_whilo       (wb_whilo),
        .wb_hi          (wb_hi),
        .wb_lo          (wb_lo),
        .wb_LLbit_we    (wb_LLbit_we),
        .wb_LLbit_value (wb_LLbit_value),
        .flush          (flush),
        .hi_o           (hi_o),
        .lo_o           (lo_o),
        .LLbit_o        (LLbit_o)
    );

endmodule : wb_regs
